// File: rtl/result_readback_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_readback_ctrl_if                                                  |
// | Result RAM read port plus element stream toward the test/host side.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface result_readback_ctrl_if #(
  parameter int OUT_WIDTH  = 32,
  parameter int ROW_A      = 4,
  parameter int ADDR_WIDTH = 8
) ();

  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [OUT_WIDTH*ROW_A-1:0]   rd_data;
  logic [OUT_WIDTH-1:0]         test_data;
  logic                         test_valid;
  logic                         test_ready;
  logic                         test_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output test_data,
    output test_valid,
    input  test_ready,
    output test_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  test_data,
    input  test_valid,
    output test_ready,
    input  test_last
  );

endinterface
`default_nettype wire

// File: rtl/result_readback_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_readback_ctrl                                                     |
// | Reads packed result words and streams them out one element at a time.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module result_readback_ctrl #(
  parameter int OUT_WIDTH  = 32,
  parameter int ROW_A      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WORDS  = 16
) (
  input  wire                    clk,
  input  wire                    reset,
  input  wire                    start,
  input  wire [ADDR_WIDTH-1:0]   base_addr,
  output logic                   busy,
  output logic                   done,
  result_readback_ctrl_if.master bus
);

  localparam int LANE_W = (ROW_A > 1) ? $clog2(ROW_A) : 1;
  localparam int CNT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WORD_W = OUT_WIDTH * ROW_A;

  localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(ROW_A - 1);
  localparam logic [CNT_W-1:0]  c_last_word = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_word_cnt;
  logic [LANE_W-1:0]     r_lane;
  logic [WORD_W-1:0]     r_shift;
  logic                  r_rd_en;
  logic                  r_test_valid;
  logic                  r_test_last;
  logic                  r_busy;
  logic                  r_done;

  logic [WORD_W-1:0]     w_shift_next;
  logic [LANE_W-1:0]     w_lane_inc;
  logic                  w_last_word;
  logic                  w_accept;

  generate
    if (ROW_A > 1) begin : g_multi_lane
      assign w_shift_next = {{OUT_WIDTH{1'b0}}, r_shift[WORD_W-1:OUT_WIDTH]};
    end else begin : g_single_lane
      assign w_shift_next = '0;
    end
  endgenerate

  assign w_lane_inc  = r_lane + 1'b1;
  assign w_last_word = (r_word_cnt == c_last_word);
  assign w_accept    = r_test_valid && bus.test_ready;

  // All outputs are registered and change together with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_word_cnt   <= '0;
      r_lane       <= '0;
      r_shift      <= '0;
      r_rd_en      <= 1'b0;
      r_test_valid <= 1'b0;
      r_test_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_word_cnt <= '0;
            r_rd_en    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_READ;
          end
        end

        S_READ: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_shift      <= bus.rd_data;
          r_lane       <= '0;
          r_test_valid <= 1'b1;
          r_test_last  <= (c_last_lane == '0) && w_last_word;
          r_state      <= S_EMIT;
        end

        S_EMIT: begin
          if (w_accept) begin
            if (r_lane != c_last_lane) begin
              r_shift     <= w_shift_next;
              r_lane      <= w_lane_inc;
              r_test_last <= (w_lane_inc == c_last_lane) && w_last_word;
            end else begin
              // Last lane of the word: advance to the next RAM word or finish.
              r_test_valid <= 1'b0;
              r_test_last  <= 1'b0;
              r_addr       <= r_addr + 1'b1;
              r_word_cnt   <= r_word_cnt + 1'b1;
              if (w_last_word) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_rd_en <= 1'b1;
                r_state <= S_READ;
              end
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_addr;
  assign bus.test_data  = r_shift[OUT_WIDTH-1:0];
  assign bus.test_valid = r_test_valid;
  assign bus.test_last  = r_test_last;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_readback_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_result_readback_ctrl                                                  |
// | Directed checks of the readback controller against hand-computed data.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_result_readback_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_a;
  logic [7:0] base_a;
  logic       busy_a;
  logic       done_a;
  logic       start_b;
  logic [7:0] base_b;
  logic       busy_b;
  logic       done_b;

  int n_checks;
  int n_fail;

  logic [127:0] mem_a [0:255];
  logic [31:0]  mem_b [0:255];

  logic [31:0] elem_q [$];
  bit          last_q [$];
  logic [7:0]  addr_q [$];
  int          done_k;

  result_readback_ctrl_if #(.OUT_WIDTH(32), .ROW_A(4), .ADDR_WIDTH(8)) bus_a ();
  result_readback_ctrl_if #(.OUT_WIDTH(32), .ROW_A(1), .ADDR_WIDTH(8)) bus_b ();

  result_readback_ctrl #(
    .OUT_WIDTH(32), .ROW_A(4), .ADDR_WIDTH(8), .NUM_WORDS(2)
  ) u_dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start_a),
    .base_addr (base_a),
    .busy      (busy_a),
    .done      (done_a),
    .bus       (bus_a.master)
  );

  result_readback_ctrl #(
    .OUT_WIDTH(32), .ROW_A(1), .ADDR_WIDTH(8), .NUM_WORDS(1)
  ) u_dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start_b),
    .base_addr (base_b),
    .busy      (busy_b),
    .done      (done_b),
    .bus       (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: garbage on cycles without a read so stray captures show up.
  always @(posedge clk) begin
    bus_a.rd_data <= bus_a.rd_en ? mem_a[bus_a.rd_addr] : {4{32'hDEADBEEF}};
    bus_b.rd_data <= bus_b.rd_en ? mem_b[bus_b.rd_addr] : 32'hDEADBEEF;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [7:0] base, input logic [3:0] rpat, input bit hold);
    bit          stalled;
    logic [31:0] held;
    elem_q.delete();
    last_q.delete();
    addr_q.delete();
    done_k  = 0;
    stalled = 1'b0;
    held    = '0;
    @(negedge clk);
    base_a  = base;
    start_a = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (!hold) start_a = 1'b0;
      if (bus_a.rd_en) addr_q.push_back(bus_a.rd_addr);
      if (done_a) begin
        done_k = k;
        break;
      end
      if (stalled) begin
        check_val("stall_valid", 32'(bus_a.test_valid), 32'd1);
        check_val("stall_data", bus_a.test_data, held);
      end
      bus_a.test_ready = rpat[k % 4];
      stalled = 1'b0;
      if (bus_a.test_valid) begin
        if (bus_a.test_ready) begin
          elem_q.push_back(bus_a.test_data);
          last_q.push_back(bus_a.test_last);
        end else begin
          stalled = 1'b1;
          held    = bus_a.test_data;
        end
      end
    end
    bus_a.test_ready = 1'b1;
    if (done_k == 0) check_val("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_elems(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    int nl;
    check_val({tag, "_count"}, 32'(elem_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < elem_q.size(); i++)
      check_val({tag, "_elem"}, elem_q[i], (i < 4) ? w0 + 32'(i) : w1 + 32'(i - 4));
    nl = 0;
    foreach (last_q[i]) if (last_q[i]) nl++;
    check_val({tag, "_last_cnt"}, 32'(nl), 32'd1);
    if (last_q.size() == 8) check_val({tag, "_last_pos"}, 32'(last_q[7]), 32'd1);
  endtask

  initial begin
    int fv_k;
    int db_k;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[8'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_a[8'h11] = {32'd8, 32'd7, 32'd6, 32'd5};
    mem_a[8'h30] = {32'h34, 32'h33, 32'h32, 32'h31};
    mem_a[8'h31] = {32'h38, 32'h37, 32'h36, 32'h35};
    mem_a[8'hFF] = {32'hF4, 32'hF3, 32'hF2, 32'hF1};
    mem_a[8'h00] = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    mem_b[8'h40] = 32'hCAFE0001;

    rst_n   = 1'b0;
    start_a = 1'b0;
    base_a  = '0;
    start_b = 1'b0;
    base_b  = '0;
    bus_a.test_ready = 1'b1;
    bus_b.test_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy",  32'(busy_a), 32'd0);
    check_val("rst_done",  32'(done_a), 32'd0);
    check_val("rst_rd_en", 32'(bus_a.rd_en), 32'd0);
    check_val("rst_valid", 32'(bus_a.test_valid), 32'd0);
    check_val("rst_last",  32'(bus_a.test_last), 32'd0);
    check_val("rst_data",  bus_a.test_data, 32'd0);
    check_val("rst_addr",  32'(bus_a.rd_addr), 32'd0);
    rst_n = 1'b1;

    // Full-rate run.
    run_a(8'h10, 4'b1111, 1'b0);
    check_elems("fast", 32'd1, 32'd5);
    check_val("fast_done_k", 32'(done_k), 32'd13);
    check_val("fast_rd_cnt", 32'(addr_q.size()), 32'd2);
    @(negedge clk);
    check_val("done_pulse", 32'(done_a), 32'd0);
    check_val("busy_fall",  32'(busy_a), 32'd0);

    // Backpressure: ready pattern 1,0,0,1.
    run_a(8'h10, 4'b1001, 1'b0);
    check_elems("stall", 32'd1, 32'd5);
    check_val("stall_rd_cnt", 32'(addr_q.size()), 32'd2);

    // start held through the run: one run, then a restart after done.
    run_a(8'h10, 4'b1111, 1'b1);
    check_elems("hold", 32'd1, 32'd5);
    check_val("hold_rd_cnt", 32'(addr_q.size()), 32'd2);
    @(negedge clk);
    check_val("hold_idle_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    check_val("hold_rerun_busy", 32'(busy_a), 32'd1);
    check_val("hold_rerun_rd_en", 32'(bus_a.rd_en), 32'd1);
    start_a = 1'b0;
    db_k = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done_a) begin
        db_k = k;
        break;
      end
    end
    check_val("hold_rerun_done", 32'(db_k != 0), 32'd1);
    @(negedge clk);

    // Address wrap.
    run_a(8'hFF, 4'b1111, 1'b0);
    check_elems("wrap", 32'hF1, 32'hA1);
    check_val("wrap_rd_cnt", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check_val("wrap_addr0", 32'(addr_q[0]), 32'hFF);
      check_val("wrap_addr1", 32'(addr_q[1]), 32'h00);
    end

    // Reset in the middle of EMIT, lane 2.
    @(negedge clk);
    base_a  = 8'h10;
    start_a = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check_val("mid_valid_pre", 32'(bus_a.test_valid), 32'd1);
    check_val("mid_data_pre",  bus_a.test_data, 32'd3);
    rst_n = 1'b0;
    #1;
    check_val("mid_valid", 32'(bus_a.test_valid), 32'd0);
    check_val("mid_busy",  32'(busy_a), 32'd0);
    check_val("mid_rd_en", 32'(bus_a.rd_en), 32'd0);
    check_val("mid_data",  bus_a.test_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(8'h30, 4'b1111, 1'b0);
    check_elems("post_rst", 32'h31, 32'h35);
    check_val("post_rst_done_k", 32'(done_k), 32'd13);

    // Single-lane, single-word configuration.
    @(negedge clk);
    base_b  = 8'h40;
    start_b = 1'b1;
    @(posedge clk);
    fv_k = 0;
    db_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (bus_b.test_valid && fv_k == 0) begin
        fv_k = k;
        check_val("b_data", bus_b.test_data, 32'hCAFE0001);
        check_val("b_last", 32'(bus_b.test_last), 32'd1);
      end
      if (done_b) begin
        db_k = k;
        break;
      end
    end
    check_val("b_first_valid_k", 32'(fv_k), 32'd3);
    check_val("b_done_k", 32'(db_k), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
